// File: rtl/fetch_queue.sv
// fetch_queue
//   DEPTH-entry FIFO sitting between IF and ID. It replaces a single IF/ID
//   register. IF keeps fetching while ID stalls, until the queue fills.
//   ID sees the head entry, or a NOP bubble (all zeros) when the queue is empty.
//
// Ports
//   clk, reset            rising-edge clock; synchronous active-low reset
//   instrIn, PCIn         entry offered by IF
//   inValid               IF presents an entry this cycle
//   full                  queue holds DEPTH entries; IF must hold its PC
//   stall                 ID cannot consume the head this cycle
//   flush                 discard every entry (branch/jump redirect)
//   instrOut, PCOut       head entry; zero when empty
//   outValid              queue non-empty
//   count                 occupancy, 0..DEPTH
module fetch_queue #(
  parameter int IW    = 32,
  parameter int AW    = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [IW-1:0] instrIn,
  input  logic [AW-1:0] PCIn,
  input  logic          inValid,
  output logic          full,
  input  logic          stall,
  input  logic          flush,
  output logic [IW-1:0] instrOut,
  output logic [AW-1:0] PCOut,
  output logic          outValid,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [IW+AW-1:0] mem_q [DEPTH];
  logic [IW+AW-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [IW+AW-1:0] head;
  logic             push, pop;

  // full comes from the registered count only, so stall never reaches it
  assign outValid = (cnt_q != '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign count    = cnt_q;

  // A full queue refuses new entries even when the head pops this same cycle
  assign push = inValid & ~full & ~flush;
  assign pop  = outValid & ~stall & ~flush;

  assign head     = mem_q[rptr_q];
  assign instrOut = outValid ? head[IW+AW-1:AW] : '0;
  assign PCOut    = outValid ? head[AW-1:0]     : '0;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) begin
      mem_d[wptr_q] = {instrIn, PCIn};
      wptr_d        = wptr_q + 1'b1;
    end
    if (pop) rptr_d = rptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    // Stale storage is harmless: the count gates every read
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage holds data only and is never reset
  always_ff @(posedge clk) begin
    if (reset) mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  localparam int IW = 32, AW = 32, DEPTH = 4, CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [IW-1:0] instrIn = '0;
  logic [AW-1:0] PCIn = '0;
  logic          inValid = 1'b0, stall = 1'b0, flush = 1'b0;
  logic          full, outValid;
  logic [IW-1:0] instrOut;
  logic [AW-1:0] PCOut;
  logic [CW-1:0] count;

  int n_chk = 0, n_fail = 0;

  // Reference model: a plain queue of {instr, pc} pairs
  logic [IW+AW-1:0] mq[$];
  // Stream log used by the wrap-around test
  logic [AW-1:0]    acc[$];

  fetch_queue #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .instrIn(instrIn), .PCIn(PCIn),
    .inValid(inValid), .full(full), .stall(stall), .flush(flush),
    .instrOut(instrOut), .PCOut(PCOut), .outValid(outValid), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [CW+2+IW+AW-1:0] model_outs();
    logic [IW+AW-1:0] h;
    h = (mq.size() != 0) ? mq[0] : '0;
    return {CW'(mq.size()), mq.size() != 0, mq.size() == DEPTH, h};
  endfunction

  // Drive one cycle of inputs, advance one edge, update the model, sample later
  task automatic cycle(input logic rst, input logic iv, input logic st,
                       input logic fl, input logic [IW-1:0] ins,
                       input logic [AW-1:0] pc);
    bit pop_m, push_m;
    reset = rst; inValid = iv; stall = st; flush = fl; instrIn = ins; PCIn = pc;
    @(posedge clk);
    if (!rst || fl) begin
      mq.delete();
    end else begin
      pop_m  = (mq.size() != 0) && !st;
      push_m = iv && (mq.size() < DEPTH);
      if (pop_m) void'(mq.pop_front());
      if (push_m) begin
        mq.push_back({ins, pc});
        acc.push_back(pc);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1111);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1111);
    n_chk++;
    if ({count, outValid, full, instrOut, PCOut} !== {CW'(0), 1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got cnt=%0d v=%b f=%b i=%h pc=%h, want all zero",
               count, outValid, full, instrOut, PCOut);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h2408_0001, 32'h3000);
    n_chk++;
    if ({outValid, instrOut, PCOut} !== {1'b1, 32'h2408_0001, 32'h3000}) begin
      n_fail++;
      $display("FAIL reset_first_push: got v=%b i=%h pc=%h, want 1 24080001 3000",
               outValid, instrOut, PCOut);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);   // drain
  endtask

  task automatic test_fill_stall();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'hA000_0000 + i, 32'h3000 + 4 * i);
      n_chk++;
      if ({count, outValid, full, instrOut, PCOut} !== model_outs()) begin
        n_fail++;
        $display("FAIL fill_model[%0d]: got %h, want %h", i,
                 {count, outValid, full, instrOut, PCOut}, model_outs());
      end
    end
    n_chk++;
    if ({count, full, PCOut} !== {CW'(4), 1'b1, 32'h3000}) begin
      n_fail++;
      $display("FAIL fill_full: got cnt=%0d f=%b pc=%h, want 4 1 3000", count, full, PCOut);
    end
    for (int i = 1; i <= 4; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      if (i < 4) begin
        n_chk++;
        if ({outValid, PCOut, instrOut} !== {1'b1, 32'h3000 + 4 * i, 32'hA000_0000 + i}) begin
          n_fail++;
          $display("FAIL fill_drain[%0d]: got v=%b pc=%h i=%h", i, outValid, PCOut, instrOut);
        end
      end
    end
    n_chk++;
    if ({count, outValid, instrOut, PCOut} !== {CW'(0), 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL fill_empty: got cnt=%0d v=%b i=%h pc=%h, want 0 0 0 0",
               count, outValid, instrOut, PCOut);
    end
  endtask

  task automatic test_streaming();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'hB000_0000 + i, 32'h3000 + 4 * i);
      n_chk++;
      if ({count, full, PCOut} !== {CW'(1), 1'b0, 32'h3000 + 4 * i}) begin
        n_fail++;
        $display("FAIL stream[%0d]: got cnt=%0d f=%b pc=%h, want 1 0 %h", i,
                 count, full, PCOut, 32'h3000 + 4 * i);
      end
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_wrap();
    logic [AW-1:0] obs[$];
    logic iv, st;
    acc.delete();
    for (int i = 0; i < 3 * DEPTH + DEPTH; i++) begin
      iv = (i < 3 * DEPTH) ? 1'($urandom_range(0, 3) != 0) : 1'b0;
      st = (i < 3 * DEPTH) ? 1'($urandom_range(0, 2) == 0) : 1'b0;
      if (outValid && !st) obs.push_back(PCOut);
      cycle(1'b1, iv, st, 1'b0, $urandom, 32'h5000 + 4 * i);
      n_chk++;
      if ({count, outValid, full, instrOut, PCOut} !== model_outs()) begin
        n_fail++;
        $display("FAIL wrap_model[%0d]: got %h, want %h", i,
                 {count, outValid, full, instrOut, PCOut}, model_outs());
      end
    end
    n_chk++;
    if (obs.size() != acc.size()) begin
      n_fail++;
      $display("FAIL wrap_len: got %0d popped, want %0d accepted", obs.size(), acc.size());
    end else begin
      foreach (obs[k]) begin
        n_chk++;
        if (obs[k] !== acc[k]) begin
          n_fail++;
          $display("FAIL wrap_seq[%0d]: got %h, want %h", k, obs[k], acc[k]);
        end
      end
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'hC0 + i, 32'h3100 + 4 * i);
    n_chk++;
    if (count !== CW'(3)) begin
      n_fail++;
      $display("FAIL flush_pre: got cnt=%0d, want 3", count);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'h3200);
    n_chk++;
    if ({count, outValid, instrOut, PCOut} !== {CW'(0), 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL flush_clear: got cnt=%0d v=%b i=%h pc=%h, want 0 0 0 0",
               count, outValid, instrOut, PCOut);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h4000);
    n_chk++;
    if ({count, outValid, PCOut, instrOut} !== {CW'(1), 1'b1, 32'h4000, 32'h0000_0013}) begin
      n_fail++;
      $display("FAIL flush_resume: got cnt=%0d v=%b pc=%h i=%h, want 1 1 4000 00000013",
               count, outValid, PCOut, instrOut);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0, 32'hD0 + i, 32'h6000 + 4 * i);
    n_chk++;
    if (full !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_pre: got full=%b, want 1", full);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hEE, 32'h6100);
    n_chk++;
    if ({count, outValid, full, instrOut, PCOut} !== {CW'(0), 1'b0, 1'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL rmid_clear: got cnt=%0d v=%b f=%b i=%h pc=%h, want all zero",
               count, outValid, full, instrOut, PCOut);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
            $urandom, 32'h7000 + 4 * i);
      n_chk++;
      if ({count, outValid, full, instrOut, PCOut} !== model_outs()) begin
        n_fail++;
        $display("FAIL rmid_resume[%0d]: got %h, want %h", i,
                 {count, outValid, full, instrOut, PCOut}, model_outs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill_stall();
    test_streaming();
    test_wrap();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised replacement for the single-entry IF/ID pipeline register. It buffers up to DEPTH fetched instruction/PC pairs between IF and ID, so IF can keep fetching while ID is stalled. The ID side sees the head entry, or a NOP bubble when empty. It adds per-entry valid tracking, back-pressure to IF, and a flush for branch/jump redirects.

## Interface
Parameters:
- IW, 32: instruction width in bits.
- AW, 32: PC width in bits.
- DEPTH, 4: number of entries; power of two, ≥ 2.
- CW, $clog2(DEPTH)+1: occupancy counter width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low (0 = reset), sampled on the rising edge of clk.
- instrIn  input  IW  instruction from IF.
- PCIn  input  AW  PC of instrIn.
- inValid  input  1  IF presents an entry this cycle.
- full  output  1  queue holds DEPTH entries; IF must hold its PC.
- stall  input  1  ID cannot consume the head this cycle (hazard unit).
- flush  input  1  discard all entries (redirect).
- instrOut  output  IW  head instruction; 0 (NOP) when empty.
- PCOut  output  AW  head PC; 0 when empty.
- outValid  output  1  head entry is valid (queue non-empty).
- count  output  CW  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH-entry circular buffer of {instr, PC}, plus write pointer, read pointer and occupancy counter.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally DEPTH-1 → 0.
- push = inValid & !full & !flush.
- pop = outValid & !stall & !flush.
- push only: write entry at wptr, wptr+1, count+1.
- pop only: rptr+1, count−1.
- push & pop together: both pointers advance and count is unchanged. Legal at any non-full, non-empty occupancy.
- Empty + push + stall: entry is written; it is not popped (outValid was 0).
- Full: inValid is ignored and no entry is written, even if a pop occurs the same cycle. full is derived from the registered count only; no combinational path from stall to full.
- flush: highest priority after reset. Next cycle count=0, wptr=rptr=0, and any simultaneous push/pop is discarded. Storage contents need not be cleared.
- reset (reset=0 at the edge): same effect as flush. Overrides all other inputs, including mid-operation.
- Outputs:
  - instrOut/PCOut = mem[rptr] when count≠0, else 0.
  - outValid = (count≠0).
  - full = (count==DEPTH).
  - All outputs are functions of registered state only.

## Timing
- Reset values, from the first edge with reset=0: count=0, outValid=0, full=0, instrOut=0, PCOut=0.
- Latency: an entry pushed into an empty queue at edge t appears on instrOut/PCOut with outValid=1 after edge t. This is the same one-cycle latency as a plain IF/ID register.
- Pop takes effect at the edge: the next entry, or the NOP bubble, appears after that edge.
- flush asserted at edge t: outValid=0 and instrOut=0 after edge t. An entry presented at edge t+1 is accepted normally.
- full rises after the edge that makes count=DEPTH and falls after the first pop edge.
- Throughput: one push and one pop per cycle sustained.

## Test plan
- Reset: drive reset=0 for 2 edges with inValid=1 → count=0, outValid=0, instrOut=0, PCOut=0. Release, push {0x24080001, 0x3000} → next cycle instrOut=0x24080001, PCOut=0x3000, outValid=1.
- Fill under stall: stall=1, push PCs 0x3000,0x3004,0x3008,0x300C, then offer 0x3010 → count=4, full=1, 0x3010 not stored. Release stall → outputs 0x3000,0x3004,0x3008,0x300C on successive cycles, then outValid=0, instrOut=0.
- Streaming: inValid=1, stall=0 for 10 cycles, PC stepping by 4 from 0x3000 → count stays 1, PCOut tracks the input delayed by one cycle, full never asserts.
- Wrap-around: run 3·DEPTH push/pop cycles with random stall → PC sequence out equals sequence accepted in, with no loss or duplication across pointer wrap.
- Flush: with count=3, assert flush together with inValid=1 and stall=0 → next cycle count=0, outValid=0, instrOut=0. A push of 0x4000 on the following cycle appears one cycle later.
- Reset mid-operation: with full=1, assert reset=0 for one edge while pushing and popping → all outputs return to their reset values and the queue resumes cleanly.
